// File: rtl/jpeg_idct_transpose_ctrl.sv
// Transpose controller for the JPEG IDCT: row-pass words are ping-ponged into two
// 32x32 banks and each 8x8 block is replayed one sample per beat in column-major order.
module jpeg_idct_transpose_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [15:0] outport_data_o,
  output logic [5:0]  outport_idx_o,
  input  logic        outport_accept_i,
  output logic [4:0]  ram_addr0_o,
  output logic [31:0] ram_data0_o,
  output logic        ram_wr0_o,
  input  logic [31:0] ram_data0_i,
  output logic [4:0]  ram_addr1_o,
  output logic [31:0] ram_data1_o,
  output logic        ram_wr1_o,
  input  logic [31:0] ram_data1_i,
  output logic        idle_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } rd_state_t;

  rd_state_t   state_r;
  rd_state_t   state_nxt_s;
  logic [1:0]  full_r;
  logic [1:0]  full_nxt_s;
  logic        wr_bank_r;
  logic        rd_bank_r;
  logic [4:0]  wr_cnt_r;
  logic [5:0]  k_r;
  logic        out_valid_r;
  logic [5:0]  out_idx_r;
  logic        half_r;

  logic        rd_busy_s;
  logic        wr_blocked_s;
  logic        wr_fire_s;
  logic        wr_last_s;
  logic        out_fire_s;
  logic        adv_s;
  logic        other_ready_s;
  logic        issue_s;
  logic        rd_done_s;
  logic [5:0]  rd_k_s;
  logic [4:0]  rd_addr_s;
  logic [31:0] rd_word_s;

  // Handshake qualifiers shared by both sides of the ping-pong.
  always_comb begin
    rd_busy_s     = (state_r != ST_IDLE);
    wr_blocked_s  = full_r[wr_bank_r] || (rd_busy_s && (rd_bank_r == wr_bank_r));
    wr_fire_s     = inport_valid_i && !wr_blocked_s;
    wr_last_s     = wr_fire_s && (wr_cnt_r == 5'd31);
    out_fire_s    = out_valid_r && outport_accept_i;
    adv_s         = !out_valid_r || outport_accept_i;
    // A block completing this very cycle counts, so the reader never detours via IDLE.
    other_ready_s = full_r[~rd_bank_r] || (wr_last_s && (wr_bank_r != rd_bank_r));
  end

  // Read FSM next state; issue_s launches address k_r into the output stage.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    rd_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rd_bank_r]) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (adv_s) begin
          issue_s = 1'b1;
          if (k_r == 6'd63) begin
            state_nxt_s = ST_LAST;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_LAST: begin
        if (out_fire_s) begin
          rd_done_s = 1'b1;
          if (other_ready_s) begin
            state_nxt_s = ST_READ;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_LAST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bank occupancy: set by the writer on word 31, cleared by the reader on sample 63.
  always_comb begin
    full_nxt_s[0] = (full_r[0] || (wr_last_s && !wr_bank_r)) && !(rd_done_s && !rd_bank_r);
    full_nxt_s[1] = (full_r[1] || (wr_last_s && wr_bank_r)) && !(rd_done_s && rd_bank_r);
  end

  // While stalled the RAM re-reads the displayed sample so its output stays put.
  always_comb begin
    if (issue_s) begin
      rd_k_s = k_r;
    end else begin
      rd_k_s = out_idx_r;
    end
    rd_addr_s = {rd_k_s[2:0], rd_k_s[5:4]};
    if (rd_bank_r) begin
      rd_word_s = ram_data1_i;
    end else begin
      rd_word_s = ram_data0_i;
    end
  end

  // Bank port steering: the read bank gets the transpose address, the other the write count.
  always_comb begin
    ram_wr0_o   = wr_fire_s && !wr_bank_r;
    ram_wr1_o   = wr_fire_s && wr_bank_r;
    ram_data0_o = inport_data_i;
    ram_data1_o = inport_data_i;
    if (rd_busy_s && !rd_bank_r) begin
      ram_addr0_o = rd_addr_s;
    end else begin
      ram_addr0_o = wr_cnt_r;
    end
    if (rd_busy_s && rd_bank_r) begin
      ram_addr1_o = rd_addr_s;
    end else begin
      ram_addr1_o = wr_cnt_r;
    end
  end

  // Output sample select; forced to zero whenever nothing is valid.
  always_comb begin
    if (!out_valid_r) begin
      outport_data_o = 16'd0;
    end else if (half_r) begin
      outport_data_o = rd_word_s[31:16];
    end else begin
      outport_data_o = rd_word_s[15:0];
    end
  end

  assign inport_accept_o = !wr_blocked_s;
  assign outport_valid_o = out_valid_r;
  assign outport_idx_o   = out_idx_r;
  assign idle_o          = (full_r == 2'b00) && (state_r == ST_IDLE) && !out_valid_r;

  // Read FSM, bank flags, read pointer and transpose counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      full_r    <= 2'b00;
      rd_bank_r <= 1'b0;
      k_r       <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      full_r  <= full_nxt_s;
      if (rd_done_s) begin
        rd_bank_r <= ~rd_bank_r;
      end else begin
        rd_bank_r <= rd_bank_r;
      end
      if (issue_s) begin
        k_r <= k_r + 6'd1;
      end else if ((state_nxt_s == ST_READ) && (state_r != ST_READ)) begin
        k_r <= 6'd0;
      end else begin
        k_r <= k_r;
      end
    end
  end

  // Write pointer and word counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_bank_r <= 1'b0;
      wr_cnt_r  <= 5'd0;
    end else if (wr_last_s) begin
      wr_bank_r <= ~wr_bank_r;
      wr_cnt_r  <= 5'd0;
    end else if (wr_fire_s) begin
      wr_bank_r <= wr_bank_r;
      wr_cnt_r  <= wr_cnt_r + 5'd1;
    end else begin
      wr_bank_r <= wr_bank_r;
      wr_cnt_r  <= wr_cnt_r;
    end
  end

  // Output stage: valid, index and half-select advance only on issue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= 6'd0;
      half_r      <= 1'b0;
    end else if (issue_s) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= k_r;
      half_r      <= k_r[3];
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= out_idx_r;
      half_r      <= half_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_idx_r   <= out_idx_r;
      half_r      <= half_r;
    end
  end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Scoreboard bench for jpeg_idct_transpose_ctrl: blocks are written row-wise and the
// column-major samples are compared against a queue filled when each block completes.
module tb_jpeg_idct_transpose_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        inport_valid_i = 1'b0;
  logic [31:0] inport_data_i = 32'd0;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [15:0] outport_data_o;
  logic [5:0]  outport_idx_o;
  logic        outport_accept_i = 1'b0;
  logic [4:0]  ram_addr0_o, ram_addr1_o;
  logic [31:0] ram_data0_o, ram_data1_o;
  logic        ram_wr0_o, ram_wr1_o;
  logic [31:0] ram_data0_i, ram_data1_i;
  logic        idle_o;

  always #5 clk = ~clk;

  jpeg_idct_transpose_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_accept_o(inport_accept_o),
    .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o), .outport_idx_o(outport_idx_o),
    .outport_accept_i(outport_accept_i),
    .ram_addr0_o(ram_addr0_o), .ram_data0_o(ram_data0_o), .ram_wr0_o(ram_wr0_o), .ram_data0_i(ram_data0_i),
    .ram_addr1_o(ram_addr1_o), .ram_data1_o(ram_data1_o), .ram_wr1_o(ram_wr1_o), .ram_data1_i(ram_data1_i),
    .idle_o(idle_o)
  );

  // Two synchronous single-port banks with one-cycle read latency.
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  always @(posedge clk) begin
    if (ram_wr0_o) mem0[ram_addr0_o] <= ram_data0_o;
    ram_data0_i <= mem0[ram_addr0_o];
    if (ram_wr1_o) mem1[ram_addr1_o] <= ram_data1_o;
    ram_data1_i <= mem1[ram_addr1_o];
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;

  int          acc_mode = 0;   // 0 always accept, 1 random 30%, 2 never, 3 hold at idx 63
  int          out_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [15:0] prev_data;
  logic [5:0]  prev_idx;
  bit          gap_meas = 1'b0;
  int          gap_cnt = 0;
  int          last_gap = -1;
  int          exp_bank = 0;

  // Output monitor: pick this cycle's accept, then score the sample about to be taken.
  always @(negedge clk) begin
    case (acc_mode)
      0: outport_accept_i = 1'b1;
      1: outport_accept_i = ($urandom_range(0, 99) < 30);
      2: outport_accept_i = 1'b0;
      default: outport_accept_i = !(outport_valid_o && (outport_idx_o == 6'd63));
    endcase
    if (!rst_i) begin
      hold_pend = 1'b0;
      gap_meas  = 1'b0;
    end else begin
      if (hold_pend) begin
        check_val("hold_valid", outport_valid_o, 1);
        check_val("hold_data", outport_data_o, prev_data);
        check_val("hold_idx", outport_idx_o, prev_idx);
      end
      if (gap_meas) begin
        if (outport_valid_o) begin
          last_gap = gap_cnt;
          gap_meas = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (outport_valid_o && outport_accept_i) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check_val("out_idx", outport_idx_o, exp_e.idx);
          check_val("out_data", outport_data_o, exp_e.data);
        end
        if (outport_idx_o == 6'd63) begin
          gap_meas = 1'b1;
          gap_cnt  = 0;
        end
      end
      hold_pend = outport_valid_o && !outport_accept_i;
      prev_data = outport_data_o;
      prev_idx  = outport_idx_o;
    end
  end

  task automatic send_word(input logic [31:0] d, input int n, output bit ok);
    int w = 0;
    inport_valid_i = 1'b1;
    inport_data_i  = d;
    #1;
    while (!inport_accept_o && w < 400) begin
      @(negedge clk); #1;
      w++;
    end
    if (!inport_accept_o) begin
      check_val("in_timeout", w, 0);
      ok = 1'b0;
      inport_valid_i = 1'b0;
    end else begin
      ok = 1'b1;
      check_val("ram_wr_bank", {ram_wr1_o, ram_wr0_o}, (exp_bank != 0) ? 2 : 1);
      check_val("ram_waddr", (exp_bank != 0) ? ram_addr1_o : ram_addr0_o, n);
      @(negedge clk);
    end
  endtask

  task automatic send_words(input int blk, input int first, input int last);
    int lo;
    bit ok;
    for (int n = first; n <= last; n++) begin
      lo = blk * 256 + (n / 4) * 8 + 2 * (n % 4);
      send_word({16'(lo + 1), 16'(lo)}, n, ok);
      if (ok && n == 31) begin
        for (int k = 0; k < 64; k++) begin
          exp_q.push_back(exp_t'{idx: 6'(k), data: 16'(blk * 256 + (k % 8) * 8 + k / 8)});
        end
        exp_bank = 1 - exp_bank;
      end
    end
    inport_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || outport_valid_o) && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    check_val("drain_left", exp_q.size(), 0);
    check_val("drain_valid", outport_valid_o, 0);
  endtask

  initial begin
    int base;
    int c;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid", outport_valid_o, 0);
    check_val("rst_data", outport_data_o, 0);
    check_val("rst_idx", outport_idx_o, 0);
    check_val("rst_wr", {ram_wr1_o, ram_wr0_o}, 0);
    rst_i = 1'b1;
    @(negedge clk); #1;
    check_val("rst_accept", inport_accept_o, 1);
    check_val("rst_idle", idle_o, 1);

    // Single block with idle reader: two-cycle latency then 64 transposed samples.
    acc_mode = 0;
    send_words(0, 0, 31);
    #1;
    check_val("lat_t0_valid", outport_valid_o, 0);
    check_val("busy_idle", idle_o, 0);
    @(negedge clk); #1;
    check_val("lat_t1_valid", outport_valid_o, 0);
    @(negedge clk); #1;
    check_val("lat_t2_valid", outport_valid_o, 1);
    wait_drain();
    check_val("single_idle", idle_o, 1);

    // Three blocks back to back; banks alternate and swaps cost one bubble.
    for (int b = 1; b <= 3; b++) send_words(b, 0, 31);
    wait_drain();
    check_val("stream_gap", last_gap, 1);

    // Random downstream backpressure.
    acc_mode = 1;
    send_words(4, 0, 31);
    wait_drain();

    // Both banks full: input must stall until the first block has fully drained.
    acc_mode = 2;
    send_words(5, 0, 31);
    send_words(6, 0, 31);
    repeat (4) @(negedge clk);
    #1;
    check_val("full_accept", inport_accept_o, 0);
    base = out_cnt;
    inport_valid_i = 1'b1;
    inport_data_i  = {16'(7 * 256 + 1), 16'(7 * 256)};
    repeat (3) @(negedge clk);
    #1;
    check_val("full_pending", inport_accept_o, 0);
    acc_mode = 0;
    c = 0;
    while (!inport_accept_o && c < 400) begin
      @(negedge clk); #1;
      c++;
    end
    check_val("restart_after_drain", out_cnt - base, 64);
    send_words(7, 0, 31);
    wait_drain();

    // Reset in the middle of a block while a drain is stalled.
    acc_mode = 2;
    send_words(8, 0, 31);
    send_words(9, 0, 16);
    check_val("pre_rst_valid", outport_valid_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check_val("midrst_valid", outport_valid_o, 0);
    check_val("midrst_data", outport_data_o, 0);
    check_val("midrst_idx", outport_idx_o, 0);
    check_val("midrst_wr", {ram_wr1_o, ram_wr0_o}, 0);
    exp_q.delete();
    exp_bank = 0;
    repeat (2) @(negedge clk);
    #1 rst_i = 1'b1;
    acc_mode = 0;
    @(negedge clk); #1;
    check_val("post_rst_idle", idle_o, 1);
    check_val("post_rst_accept", inport_accept_o, 1);
    repeat (10) @(negedge clk);
    #1;
    check_val("post_rst_quiet", outport_valid_o, 0);
    send_words(10, 0, 31);
    wait_drain();

    // Bank swap: sample 63 handshake lands on the same edge as the other bank's word 31.
    acc_mode = 3;
    send_words(11, 0, 31);
    send_words(12, 0, 30);
    c = 0;
    while (!(outport_valid_o && outport_idx_o == 6'd63) && c < 500) begin
      @(negedge clk); #1;
      c++;
    end
    check_val("swap_at_63", outport_idx_o, 63);
    acc_mode = 0;
    @(negedge clk);
    check_val("swap_in_ready", inport_accept_o, 1);
    send_words(12, 31, 31);
    wait_drain();
    check_val("swap_gap", last_gap, 1);
    check_val("final_idle", idle_o, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jpeg_idct_transpose_ctrl.md
JPEG_IDCT_TRANSPOSE_CTRL -- requirements
Module: jpeg_idct_transpose_ctrl

Interface
REQ-001 SHALL have no parameters; every width is fixed by this document.
REQ-002 SHALL have port `clk_i`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst_i`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port `inport_valid_i`, input, 1 bit: a row-pass word is offered.
REQ-005 SHALL have port `inport_data_i`, input, 32 bits: two samples of one row; [15:0] is the even column, [31:16] the odd column.
REQ-006 SHALL have port `inport_accept_o`, output, 1 bit: the word is taken when `inport_valid_i` && `inport_accept_o`.
REQ-007 SHALL have port `outport_valid_o`, output, 1 bit: a column-order sample is valid.
REQ-008 SHALL have port `outport_data_o`, output, 16 bits: the sample.
REQ-009 SHALL have port `outport_idx_o`, output, 6 bits: column-major index k = col*8+row.
REQ-010 SHALL have port `outport_accept_i`, input, 1 bit: downstream takes the sample.
REQ-011 SHALL have ports `ram_addr0_o`, output, 5 bits; `ram_data0_o`, output, 32 bits; `ram_wr0_o`, output, 1 bit; `ram_data0_i`, input, 32 bits: bank 0, a synchronous single-port 32x32 memory with 1-cycle read latency.
REQ-012 SHALL have ports `ram_addr1_o`, `ram_data1_o`, `ram_wr1_o`, `ram_data1_i`, identical to REQ-011 for bank 1.
REQ-013 SHALL have port `idle_o`, output, 1 bit: both banks empty and no read in flight.

Function
REQ-014 SHALL operate the two banks as a ping-pong pair; in any cycle a bank is either written or read, never both.
REQ-015 SHALL keep per bank an empty/full flag, plus a write-bank pointer `wr_bank` and a read-bank pointer `rd_bank`.
REQ-016 SHALL drive `inport_accept_o` = 1 only when bank `wr_bank` is empty and not being read.
REQ-017 SHALL, on each accepted word n (0..31), write it to address n of `wr_bank` in the same cycle (`ram_wrX_o`=1); n is a 5-bit counter.
REQ-018 SHALL, on the accept of word 31, mark `wr_bank` full, toggle `wr_bank` and clear n, all at the next edge.
REQ-019 SHALL run a read FSM with states IDLE, READ and LAST.
REQ-020 SHALL move IDLE->READ when bank `rd_bank` is full, with k=0.
REQ-021 SHALL, in READ, present address {k[2:0], k[5:4]} (row*4 + col/2) to `rd_bank`; half-select is k[3] (1 = [31:16]).
REQ-022 SHALL assert `outport_valid_o` from the cycle after the first address is presented until the block ends.
REQ-023 SHALL drive `outport_data_o` from the RAM output through the registered half-select, and `outport_idx_o` = registered k.
REQ-024 SHALL, while `outport_valid_o` && !`outport_accept_i`, hold the address, k and the half-select; data, idx and valid stay stable (no bubbles, no drops).
REQ-025 SHALL, on each output handshake, advance k by 1; on the handshake with k=63, mark `rd_bank` empty and toggle `rd_bank` (LAST->IDLE), or, if the other bank is already full, go straight to READ with k=0.
REQ-026 SHALL have latency of 2 cycles from the accept edge of word 31 to `outport_valid_o`=1 (reader idle).
REQ-027 SHALL sustain 1 output sample per cycle under continuous accept; 64 samples per block.
REQ-028 SHALL have no bypass when a bank is freed: a bank emptied at edge t is writable from cycle t+1.
REQ-029 SHALL drive `inport_accept_o`=0 when both banks are full; a pending input waits.
REQ-030 SHALL keep `ram_wrX_o`=0 on the bank being read; its address is don't-care when the bank is unused.

Reset
REQ-031 SHALL, on `rst_i` low, asynchronously clear: both flags to empty; `wr_bank`=`rd_bank`=0; n=k=0; FSM=IDLE; `outport_valid_o`=0; `outport_data_o`=0; `outport_idx_o`=0; `ram_wr0_o`=`ram_wr1_o`=0.
REQ-032 SHALL, after reset, drive `inport_accept_o`=1 and `idle_o`=1.
REQ-033 SHALL discard any partially written or partially drained block on a reset mid-operation; no output follows the release.

Verification
REQ-034 SHALL cover single block: 32 words, row r word w = {16'(r*8+2w+1), 16'(r*8+2w)}, accept=1 -> 64 outputs, idx k carries value (k%8)*8+k/8, first valid 2 cycles after word 31.
REQ-035 SHALL cover back-to-back blocks: 3 blocks streamed continuously -> bank alternates 0,1,0; no lost or duplicated samples; input stalls only while both banks are full.
REQ-036 SHALL cover backpressure: random `outport_accept_i` at 30% -> data and idx held stable during stalls; sequence identical to REQ-034.
REQ-037 SHALL cover both banks full: hold `outport_accept_i`=0 and send 64 words -> `inport_accept_o` drops after word 63; raising accept restarts input once the first block is drained.
REQ-038 SHALL cover reset mid-block: assert `rst_i` after 17 words -> outputs cleared immediately, `idle_o`=1 after release; a fresh block then decodes correctly.
REQ-039 SHALL cover bank swap: the k=63 handshake coincides with the other bank becoming full -> READ restarts with no IDLE cycle and the next `outport_valid_o` is continuous.
